// File: rtl/iir_fb_if.sv
// ============================================================================
// Interface : iir_fb_if
// Brief     : Sample, result and coefficient-bank signals of the IIR feedback
//             stage. master = upstream / controller, slave = iir_fb.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iir_fb_if #(
  parameter int PRECISION = 16,
  parameter int COEF_W    = 16,
  parameter int ORDER     = 2
) ();
  localparam int c_ADDR_W = $clog2(ORDER + 1);

  logic signed [PRECISION-1:0] w;
  logic                        w_valid;
  logic                        w_ready;
  logic signed [PRECISION-1:0] y;
  logic                        y_valid;
  logic                        coef_we;
  logic [c_ADDR_W-1:0]         coef_addr;
  logic signed [COEF_W-1:0]    coef_data;
  logic                        hist_clr;

  modport master (
    output w, w_valid, coef_we, coef_addr, coef_data, hist_clr,
    input  w_ready, y, y_valid
  );

  modport slave (
    input  w, w_valid, coef_we, coef_addr, coef_data, hist_clr,
    output w_ready, y, y_valid
  );
endinterface

`default_nettype wire

// File: rtl/iir_fb.sv
// ============================================================================
// Module    : iir_fb
// Brief     : Recursive stage of the IIR filter, y[n] = w[n] - sum a_k*y[n-k],
//             one time-shared MAC over ORDER cycles per sample, loadable
//             coefficient bank, result saturated to PRECISION bits.
// Options   : define IIR_FB_ROUND_EN for round-half-up before the final
//             shift; otherwise the shift truncates toward minus infinity.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_fb #(
  parameter int PRECISION = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int ORDER     = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  iir_fb_if.slave   bus
);
  localparam int c_ADDR_W = $clog2(ORDER + 1);
  localparam int c_PROD_W = PRECISION + COEF_W;
  // One guard bit beyond the growth of ORDER products keeps acc from wrapping
  localparam int c_ACC_W  = PRECISION + COEF_W + $clog2(ORDER) + 1;
  localparam logic [c_ADDR_W-1:0] c_K_LAST = c_ADDR_W'(ORDER);
  localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
    {{(c_ACC_W-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
  localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
    {{(c_ACC_W-PRECISION+1){1'b1}}, {(PRECISION-1){1'b0}}};
`ifdef IIR_FB_ROUND_EN
  localparam logic signed [c_ACC_W-1:0] c_RND_HALF = c_ACC_W'(1) << (COEF_FRAC - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                      r_state;
  logic signed [c_ACC_W-1:0]   r_acc;
  logic [c_ADDR_W-1:0]         r_k;
  logic signed [COEF_W-1:0]    r_coef [1:ORDER];
  logic signed [PRECISION-1:0] r_hist [1:ORDER];
  logic signed [PRECISION-1:0] r_y;
  logic                        r_y_valid;
  logic                        r_w_ready;

  logic signed [c_PROD_W-1:0]  w_prod;
  logic signed [c_ACC_W-1:0]   w_acc_next;
  logic signed [c_ACC_W-1:0]   w_rnd;
  logic signed [c_ACC_W-1:0]   w_shift;
  logic signed [PRECISION-1:0] w_sat;
  logic                        w_addr_ok;

  assign w_prod     = c_PROD_W'(r_hist[r_k]) * c_PROD_W'(r_coef[r_k]);
  assign w_acc_next = r_acc - c_ACC_W'(w_prod);
`ifdef IIR_FB_ROUND_EN
  assign w_rnd      = w_acc_next + c_RND_HALF;
`else
  assign w_rnd      = w_acc_next;
`endif
  assign w_shift    = w_rnd >>> COEF_FRAC;
  assign w_addr_ok  = (bus.coef_addr != '0) && (bus.coef_addr <= c_K_LAST);

  // Clamp the scaled accumulator into the signed sample range
  always_comb begin
    w_sat = w_shift[PRECISION-1:0];
    if (w_shift > c_SAT_MAX) begin
      w_sat = c_SAT_MAX[PRECISION-1:0];
    end else if (w_shift < c_SAT_MIN) begin
      w_sat = c_SAT_MIN[PRECISION-1:0];
    end
  end

  // Coefficient bank; writes land at the edge, so a MAC reading the same
  // entry in that cycle still sees the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= ORDER; i++) r_coef[i] <= '0;
    end else if (bus.coef_we && w_addr_ok) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Sample FSM: accept w, run ORDER MAC steps, publish y during OUT.
  // The result is registered on the last MAC edge so y_valid is high in OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_k       <= c_ADDR_W'(1);
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_w_ready <= 1'b1;
      for (int i = 1; i <= ORDER; i++) r_hist[i] <= '0;
    end else if (bus.hist_clr) begin
      r_state   <= S_IDLE;
      r_k       <= c_ADDR_W'(1);
      r_y_valid <= 1'b0;
      r_w_ready <= 1'b1;
      for (int i = 1; i <= ORDER; i++) r_hist[i] <= '0;
    end else begin
      r_y_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.w_valid) begin
            r_acc     <= c_ACC_W'(bus.w) <<< COEF_FRAC;
            r_k       <= c_ADDR_W'(1);
            r_w_ready <= 1'b0;
            r_state   <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_k == c_K_LAST) begin
            r_y       <= w_sat;
            r_y_valid <= 1'b1;
            for (int i = ORDER; i >= 2; i--) r_hist[i] <= r_hist[i-1];
            r_hist[1] <= w_sat;
            r_state   <= S_OUT;
          end else begin
            r_k <= r_k + c_ADDR_W'(1);
          end
        end
        S_OUT: begin
          r_k       <= c_ADDR_W'(1);
          r_w_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_w_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.y       = r_y;
  assign bus.y_valid = r_y_valid;
  assign bus.w_ready = r_w_ready;
endmodule

`default_nettype wire
